// File: rtl/frog_game_pkg.sv
// Shared types and constants for the frog game flow controller.
package frog_game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        HIT       = 3'd2,
        LEVEL_UP  = 3'd3,
        GAME_OVER = 3'd4,
        VICTORY   = 3'd5
    } state_t;

    localparam logic [7:0] SEL_BACKGROUND = 8'd0;

    localparam int OBJ_WATERFALL = 0;
    localparam int OBJ_LOG       = 1;
    localparam int OBJ_FROG      = 2;
    localparam int OBJ_ENDBANK   = 3;

endpackage

// File: rtl/obj_priority_enc.sv
// Lowest-bit-first draw request encoder: object k maps to k+1, nothing maps to background.
module obj_priority_enc
    import frog_game_pkg::*;
#(
    parameter int NUM_OBJ = 8
) (
    input  logic [NUM_OBJ-1:0] req_i,
    output logic [7:0]         sel_o
);

    always_comb begin
        sel_o = SEL_BACKGROUND;
        // Scan from the top so the lowest set bit is written last and wins.
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                sel_o = 8'(i + 1);
            end
        end
    end

endmodule

// File: rtl/frog_game_fsm.sv
// Game-flow controller: draw priority, per-frame frog collision evaluation, lives/levels and pauses.
module frog_game_fsm
    import frog_game_pkg::*;
#(
    parameter int NUM_OBJ     = 8,
    parameter int FROG_IDX    = OBJ_FROG,
    parameter int LIVES       = 3,
    parameter int LEVELS      = 4,
    parameter int HOLD_FRAMES = 60
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               start_game,
    input  logic [NUM_OBJ-1:0] draw_req,
    input  logic [NUM_OBJ-1:0] lose_mask,
    input  logic [NUM_OBJ-1:0] win_mask,
    output logic [7:0]         select_mux,
    output logic               win,
    output logic               lose,
    output logic               frog_respawn,
    output logic               freeze,
    output logic [3:0]         lives_left,
    output logic [3:0]         level,
    output logic               game_over,
    output logic               victory
);

    localparam int                 CNT_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [NUM_OBJ-1:0] FROG_BIT = NUM_OBJ'(1) << FROG_IDX;

    state_t         state_q, state_d;
    logic [3:0]     lives_q, lives_d;
    logic [3:0]     level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           hit_f_q, hit_f_d;
    logic           win_f_q, win_f_d;
    logic           win_q, win_d;
    logic           lose_q, lose_d;
    logic           resp_q, resp_d;

    logic [NUM_OBJ-1:0] others;
    logic               hit_now;
    logic               win_now;
    logic               hold_done;

    obj_priority_enc #(.NUM_OBJ(NUM_OBJ)) u_prio (
        .req_i (draw_req),
        .sel_o (select_mux)
    );

    assign others    = draw_req & ~FROG_BIT;
    assign hit_now   = draw_req[FROG_IDX] && |(others & lose_mask);
    assign win_now   = draw_req[FROG_IDX] && |(others & win_mask);
    assign hold_done = (cnt_q == CNT_W'(HOLD_FRAMES - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            lives_q <= 4'(LIVES);
            level_q <= 4'd0;
            cnt_q   <= '0;
            hit_f_q <= 1'b0;
            win_f_q <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            hit_f_q <= hit_f_d;
            win_f_q <= win_f_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            resp_q  <= resp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        hit_f_d = hit_f_q;
        win_f_d = win_f_q;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        resp_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_game) begin
                    state_d = PLAY;
                    resp_d  = 1'b1;
                end
            end
            PLAY: begin
                if (startOfFrame) begin
                    // Collisions seen on the frame-start cycle belong to the new frame.
                    hit_f_d = hit_now;
                    win_f_d = win_now;
                    if (hit_f_q) begin
                        lose_d  = 1'b1;
                        lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
                        state_d = (lives_q <= 4'd1) ? GAME_OVER : HIT;
                        hit_f_d = 1'b0;
                        win_f_d = 1'b0;
                    end else if (win_f_q) begin
                        win_d   = 1'b1;
                        hit_f_d = 1'b0;
                        win_f_d = 1'b0;
                        if (level_q >= 4'(LEVELS - 1)) begin
                            state_d = VICTORY;
                        end else begin
                            level_d = level_q + 4'd1;
                            state_d = LEVEL_UP;
                        end
                    end
                end else begin
                    hit_f_d = hit_f_q | hit_now;
                    win_f_d = win_f_q | win_now;
                end
            end
            HIT, LEVEL_UP: begin
                if (startOfFrame) begin
                    if (hold_done) begin
                        cnt_d   = '0;
                        resp_d  = 1'b1;
                        state_d = PLAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            GAME_OVER, VICTORY: begin
                if (start_game) begin
                    state_d = PLAY;
                    lives_d = 4'(LIVES);
                    level_d = 4'd0;
                    resp_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign win          = win_q;
    assign lose         = lose_q;
    assign frog_respawn = resp_q;
    assign freeze       = (state_q != PLAY);
    assign lives_left   = lives_q;
    assign level        = level_q;
    assign game_over    = (state_q == GAME_OVER);
    assign victory      = (state_q == VICTORY);

endmodule

// File: tb/tb_frog_game_fsm.sv
// Self-checking bench for frog_game_fsm: directed scenarios plus randomized play against a frame-level model.
module tb_frog_game_fsm;

    localparam int NUM_OBJ  = 8;
    localparam int FROG_IDX = 2;
    localparam int LIVES    = 3;
    localparam int LEVELS   = 2;
    localparam int HOLD     = 40;
    localparam int FRAME    = 6;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       start_game = 1'b0;
    logic [7:0] draw_req = 8'h00;
    logic [7:0] lose_mask = 8'h01;
    logic [7:0] win_mask = 8'h08;
    logic [7:0] select_mux;
    logic       win, lose, frog_respawn, freeze, game_over, victory;
    logic [3:0] lives_left, level;

    int errors = 0;
    int checks = 0;

    frog_game_fsm #(
        .NUM_OBJ(NUM_OBJ), .FROG_IDX(FROG_IDX), .LIVES(LIVES),
        .LEVELS(LEVELS), .HOLD_FRAMES(HOLD)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_game(start_game),
        .draw_req(draw_req), .lose_mask(lose_mask), .win_mask(win_mask),
        .select_mux(select_mux), .win(win), .lose(lose), .frog_respawn(frog_respawn),
        .freeze(freeze), .lives_left(lives_left), .level(level),
        .game_over(game_over), .victory(victory)
    );

    always #5 clk = ~clk;

    // Frame-level game model: pauses (hit or level-up) are one mode with a frame countdown.
    typedef enum {M_IDLE, M_PLAY, M_PAUSE, M_OVER, M_VICT} mmode_t;
    mmode_t m_mode;
    int     m_lives, m_level, m_pause_left;
    bit     m_fr_hit, m_fr_win;
    bit     e_win, e_lose, e_resp;

    function automatic int ref_sel(input logic [7:0] r);
        for (int i = 0; i < NUM_OBJ; i++) if (r[i]) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_lives = LIVES; m_level = 0; m_pause_left = 0;
        m_fr_hit = 0; m_fr_win = 0; e_win = 0; e_lose = 0; e_resp = 0;
    endtask

    task automatic model_step(input bit sof, input bit st, input logic [7:0] req);
        logic [7:0] oth;
        bit lethal, goal;
        oth = req;
        oth[FROG_IDX] = 1'b0;
        lethal = req[FROG_IDX] && ((oth & lose_mask) != 0);
        goal   = req[FROG_IDX] && ((oth & win_mask) != 0);
        e_win = 0; e_lose = 0; e_resp = 0;
        case (m_mode)
            M_IDLE: if (st) begin m_mode = M_PLAY; e_resp = 1; end
            M_PLAY: begin
                if (!sof) begin
                    m_fr_hit |= lethal;
                    m_fr_win |= goal;
                end else begin
                    if (m_fr_hit) begin
                        e_lose = 1;
                        m_lives = m_lives - 1;
                        m_mode = (m_lives == 0) ? M_OVER : M_PAUSE;
                        m_pause_left = HOLD;
                    end else if (m_fr_win) begin
                        e_win = 1;
                        if (m_level == LEVELS - 1) m_mode = M_VICT;
                        else begin m_level++; m_mode = M_PAUSE; m_pause_left = HOLD; end
                    end
                    m_fr_hit = (m_mode == M_PLAY) && lethal;
                    m_fr_win = (m_mode == M_PLAY) && goal;
                end
            end
            M_PAUSE: if (sof) begin
                m_pause_left--;
                if (m_pause_left == 0) begin
                    m_mode = M_PLAY; e_resp = 1; m_fr_hit = 0; m_fr_win = 0;
                end
            end
            default: if (st) begin
                m_mode = M_PLAY; m_lives = LIVES; m_level = 0; e_resp = 1;
                m_fr_hit = 0; m_fr_win = 0;
            end
        endcase
    endtask

    task automatic tick(input bit sof, input bit st, input logic [7:0] req);
        startOfFrame = sof;
        start_game   = st;
        draw_req     = req;
        @(posedge clk);
        #1;
        model_step(sof, st, req);
    endtask

    // One frame with req shown on its first cycle, closed by a frame-start pulse.
    task automatic frame(input logic [7:0] req);
        tick(0, 0, req);
        for (int i = 0; i < FRAME - 2; i++) tick(0, 0, 8'h00);
        tick(1, 0, 8'h00);
    endtask

    task automatic hold_out(input string name);
        for (int k = 1; k <= HOLD; k++) begin
            for (int i = 0; i < FRAME - 1; i++) tick(0, 0, 8'h00);
            tick(1, 0, 8'h00);
            if (k == HOLD - 1) begin
                checks++;
                if (freeze !== 1'b1 || frog_respawn !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_pre_release: freeze=%b respawn=%b required freeze=1 respawn=0",
                             name, freeze, frog_respawn);
                end
            end
        end
        checks++;
        if (frog_respawn !== 1'b1 || freeze !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: respawn=%b freeze=%b required respawn=1 freeze=0",
                     name, frog_respawn, freeze);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (freeze !== 1'b1 || lives_left !== 4'd3 || level !== 4'd0 || game_over !== 1'b0 ||
            victory !== 1'b0 || win !== 1'b0 || lose !== 1'b0 || frog_respawn !== 1'b0) begin
            errors++;
            $display("FAIL reset: frz=%b lives=%0d lvl=%0d go=%b vic=%b w=%b l=%b r=%b required 1,3,0,0,0,0,0,0",
                     freeze, lives_left, level, game_over, victory, win, lose, frog_respawn);
        end
        model_reset();
        @(posedge clk);
        #1 resetN = 1'b1;
        $display("reset: lives=%0d level=%0d freeze=%b", lives_left, level, freeze);
    endtask

    task automatic test_priority();
        logic [7:0] vec [3];
        int         want [3];
        vec[0] = 8'b0000_0110; want[0] = 2;
        vec[1] = 8'b0000_0000; want[1] = 0;
        vec[2] = 8'b1000_0000; want[2] = 8;
        for (int i = 0; i < 3; i++) begin
            draw_req = vec[i];
            #1;
            checks++;
            if (select_mux !== 8'(want[i])) begin
                errors++;
                $display("FAIL priority: req=%b sel=%0d required %0d", vec[i], select_mux, want[i]);
            end
            $display("priority: req=%b sel=%0d", vec[i], select_mux);
        end
        draw_req = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lose_path();
        tick(0, 1, 8'h00);
        checks++;
        if (frog_respawn !== 1'b1 || freeze !== 1'b0) begin
            errors++;
            $display("FAIL start: respawn=%b freeze=%b required 1 0", frog_respawn, freeze);
        end
        tick(1, 0, 8'h00);
        tick(0, 1, 8'h00);
        checks++;
        if (frog_respawn !== 1'b0) begin
            errors++;
            $display("FAIL start_in_play: respawn=%b required 0", frog_respawn);
        end
        frame(8'h05);
        checks++;
        if (lose !== 1'b1 || lives_left !== 4'd2 || freeze !== 1'b1) begin
            errors++;
            $display("FAIL lose_eval: lose=%b lives=%0d freeze=%b required 1 2 1", lose, lives_left, freeze);
        end
        $display("lose: lives=%0d freeze=%b", lives_left, freeze);
        hold_out("lose_hold");
    endtask

    task automatic test_game_over();
        frame(8'h05);
        hold_out("go_hold");
        frame(8'h05);
        checks++;
        if (lives_left !== 4'd0 || game_over !== 1'b1 || lose !== 1'b1) begin
            errors++;
            $display("FAIL game_over: lives=%0d go=%b lose=%b required 0 1 1", lives_left, game_over, lose);
        end
        frame(8'h05);
        checks++;
        if (lives_left !== 4'd0 || lose !== 1'b0) begin
            errors++;
            $display("FAIL no_underflow: lives=%0d lose=%b required 0 0", lives_left, lose);
        end
        tick(0, 1, 8'h00);
        checks++;
        if (lives_left !== 4'd3 || level !== 4'd0 || freeze !== 1'b0 || frog_respawn !== 1'b1 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart: lives=%0d lvl=%0d frz=%b r=%b go=%b required 3 0 0 1 0",
                     lives_left, level, freeze, frog_respawn, game_over);
        end
        $display("game_over: restarted lives=%0d", lives_left);
    endtask

    task automatic test_simultaneous();
        frame(8'h00);
        frame(8'h0D);
        checks++;
        if (lose !== 1'b1 || win !== 1'b0 || level !== 4'd0 || lives_left !== 4'd2) begin
            errors++;
            $display("FAIL simultaneous: lose=%b win=%b lvl=%0d lives=%0d required 1 0 0 2",
                     lose, win, level, lives_left);
        end
        $display("simultaneous: lose=%b win=%b", lose, win);
        hold_out("sim_hold");
    endtask

    task automatic test_level_victory();
        frame(8'h0C);
        checks++;
        if (win !== 1'b1 || level !== 4'd1 || freeze !== 1'b1 || victory !== 1'b0) begin
            errors++;
            $display("FAIL level_up: win=%b lvl=%0d frz=%b vic=%b required 1 1 1 0", win, level, freeze, victory);
        end
        hold_out("lvl_hold");
        frame(8'h0C);
        checks++;
        if (win !== 1'b1 || victory !== 1'b1 || level !== 4'd1) begin
            errors++;
            $display("FAIL victory: win=%b vic=%b lvl=%0d required 1 1 1", win, victory, level);
        end
        $display("victory: level=%0d victory=%b", level, victory);
    endtask

    task automatic test_sof_boundary();
        tick(0, 1, 8'h00);
        tick(1, 0, 8'h00);
        for (int i = 0; i < FRAME - 1; i++) tick(0, 0, 8'h00);
        tick(1, 0, 8'h05);
        checks++;
        if (lose !== 1'b0 || freeze !== 1'b0) begin
            errors++;
            $display("FAIL sof_collision_early: lose=%b frz=%b required 0 0", lose, freeze);
        end
        for (int i = 0; i < FRAME - 1; i++) tick(0, 0, 8'h00);
        tick(1, 0, 8'h00);
        checks++;
        if (lose !== 1'b1 || lives_left !== 4'd2) begin
            errors++;
            $display("FAIL sof_collision_next: lose=%b lives=%0d required 1 2", lose, lives_left);
        end
        $display("sof_boundary: lose=%b lives=%0d", lose, lives_left);
    endtask

    task automatic test_reset_mid_hit();
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < FRAME - 1; i++) tick(0, 0, 8'h00);
            tick(1, 0, 8'h00);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (freeze !== 1'b1 || lives_left !== 4'd3 || level !== 4'd0 || win !== 1'b0 ||
            lose !== 1'b0 || frog_respawn !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hit: frz=%b lives=%0d lvl=%0d w=%b l=%b r=%b go=%b required 1 3 0 0 0 0 0",
                     freeze, lives_left, level, win, lose, frog_respawn, game_over);
        end
        model_reset();
        @(posedge clk);
        #1 resetN = 1'b1;
        tick(0, 1, 8'h00);
        frame(8'h05);
        hold_out("post_reset_hold");
        $display("reset_mid_hit: lives=%0d", lives_left);
    endtask

    task automatic test_random();
        int len;
        logic [7:0] req;
        for (int f = 0; f < 800; f++) begin
            len = $urandom_range(2, 8);
            lose_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h01;
            win_mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h08;
            for (int c = 0; c < len; c++) begin
                for (int b = 0; b < 8; b++) req[b] = ($urandom_range(0, 5) == 0);
                tick(c == 0, $urandom_range(0, 39) == 0, req);
                checks++;
                if (select_mux !== 8'(ref_sel(req)) || win !== e_win || lose !== e_lose ||
                    frog_respawn !== e_resp || freeze !== (m_mode != M_PLAY) ||
                    lives_left !== 4'(m_lives) || level !== 4'(m_level) ||
                    game_over !== (m_mode == M_OVER) || victory !== (m_mode == M_VICT)) begin
                    errors++;
                    $display("FAIL random f=%0d c=%0d: sel=%0d w=%b l=%b r=%b frz=%b lives=%0d lvl=%0d go=%b vic=%b required %0d %b %b %b %b %0d %0d %b %b",
                             f, c, select_mux, win, lose, frog_respawn, freeze, lives_left, level,
                             game_over, victory, ref_sel(req), e_win, e_lose, e_resp,
                             m_mode != M_PLAY, m_lives, m_level, m_mode == M_OVER, m_mode == M_VICT);
                end
            end
            if (f % 100 == 0) $display("random: frame %0d lives=%0d level=%0d", f, lives_left, level);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_lose_path();
        test_game_over();
        test_simultaneous();
        test_level_victory();
        test_sof_boundary();
        test_reset_mid_hit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
